// File: rtl/run_ctrl_pkg.sv
// Shared constants and types for the run-button interrupt controller.
package run_ctrl_pkg;

  // Avalon word addresses of the register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge qualification modes for the capture register
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Debounce FSM states
  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } db_state_t;

endpackage

// File: rtl/run_debounce.sv
// Two-flop synchroniser, debounce FSM with saturating stability counter,
// and a registered, mode-filtered edge pulse aligned with the level change.
import run_ctrl_pkg::*;

module run_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_MODE       = 0,
  parameter logic        IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_port,
  output logic o_level,
  output logic o_edge
);

  localparam int unsigned    CW       = 24;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    r_sync;
  logic          w_s;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_rise;
  logic          w_fall;
  logic          w_edge_sel;
  logic          r_edge;

  assign w_s = r_sync[1];

  // Synchronise the asynchronous input into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {IDLE_LEVEL, IDLE_LEVEL};
    end else begin
      r_sync <= {r_sync[0], in_port};
    end
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE_LEVEL ? STABLE_HI : STABLE_LO;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic: the transition fires while the counter moves to
  // DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive equal samples.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_count_nxt = '0;
          w_state_nxt = CHECK_HI;
        end
      end
      CHECK_HI: begin
        if (!w_s) begin
          w_count_nxt = '0;
          w_state_nxt = STABLE_LO;
        end else begin
          if (r_count != '1) w_count_nxt = r_count + 1'b1;
          if (r_count >= CNT_LAST) begin
            w_state_nxt = STABLE_HI;
            w_rise      = 1'b1;
          end
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_count_nxt = '0;
          w_state_nxt = CHECK_LO;
        end
      end
      CHECK_LO: begin
        if (w_s) begin
          w_count_nxt = '0;
          w_state_nxt = STABLE_HI;
        end else begin
          if (r_count != '1) w_count_nxt = r_count + 1'b1;
          if (r_count >= CNT_LAST) begin
            w_state_nxt = STABLE_LO;
            w_fall      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_count_nxt = '0;
      end
    endcase
  end

  // Select which debounced transitions qualify as capture events
  always_comb begin
    w_edge_sel = 1'b0;
    case (EDGE_MODE)
      EDGE_RISING:  w_edge_sel = w_rise;
      EDGE_FALLING: w_edge_sel = w_fall;
      default:      w_edge_sel = w_rise | w_fall;
    endcase
  end

  // Edge pulse is registered so it is high in the first cycle of the new level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= 1'b0;
    end else begin
      r_edge <= w_edge_sel;
    end
  end

  assign o_level = (r_state == STABLE_HI) || (r_state == CHECK_LO);
  assign o_edge  = r_edge;

endmodule

// File: rtl/run_button_irq_ctrl.sv
// Avalon-MM slave for the run input: register file, bus decode and irq.
import run_ctrl_pkg::*;

module run_button_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_MODE       = 0,
  parameter logic        IDLE_LEVEL      = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic        w_level;
  logic        w_edge;
  logic        w_wr;
  logic        r_irqmask;
  logic        r_edgecap;
  logic        r_irq;
  logic [31:0] r_readdata;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  run_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .EDGE_MODE       (EDGE_MODE),
    .IDLE_LEVEL      (IDLE_LEVEL)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .o_level (w_level),
    .o_edge  (w_edge)
  );

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata[31:1];

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= 1'b0;
    end else if (w_wr && (address == ADDR_IRQMASK)) begin
      r_irqmask <= writedata[0];
    end
  end

  // Sticky edge capture; a new edge wins over a simultaneous W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= 1'b0;
    end else if (w_edge) begin
      r_edgecap <= 1'b1;
    end else if (w_wr && (address == ADDR_EDGECAP) && writedata[0]) begin
      r_edgecap <= 1'b0;
    end
  end

  // Read mux over the pre-write register state
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:    w_rdata[0] = w_level;
      ADDR_IRQMASK: w_rdata[0] = r_irqmask;
      ADDR_EDGECAP: w_rdata[0] = r_edgecap;
      default:      w_rdata    = '0;
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rdata;
      r_irq      <= r_edgecap & r_irqmask;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
